// File: rtl/time_set_ctrl.sv
// Time-setting front end for the seconds counter: debounced buttons, snapshot of
// the live count into h/m/s fields, per-field editing with wrap, and load-back.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned DB_W            = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        onehz,
  input  logic [16:0] cur_seconds,
  output logic        setting,
  output logic        load,
  output logic [16:0] load_value,
  output logic [7:0]  blank_mask
);

  typedef enum logic [2:0] {RUN, CONV_H, CONV_M, SET_H, SET_M, SET_S, APPLY} state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            db_level_q, db_level_d, db_prev_q;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]            press;
  logic                  mode_p, up_p, down_p;

  state_t      state_q, state_d;
  logic [16:0] scratch_q, scratch_d;
  logic [4:0]  hr_q, hr_d;
  logic [5:0]  mn_q, mn_d, sc_q, sc_d;
  logic [16:0] load_value_q, load_value_d;
  logic [7:0]  blank_q, blank_d;

  assign btn_raw = {btn_down, btn_up, btn_mode};

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      db_level_d[i] = db_level_q[i];
      db_cnt_d[i]   = '0;
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_level_d[i] = sync2_q[i];
        else                        db_cnt_d[i]   = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press  = db_level_q & ~db_prev_q;
  assign mode_p = press[0];
  assign up_p   = press[1];
  assign down_p = press[2];

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic inc, input logic dec);
    step_field = v;
    if (inc && !dec)      step_field = (v == max_v) ? 6'd0 : v + 6'd1;
    else if (dec && !inc) step_field = (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    hr_d      = hr_q;
    mn_d      = mn_q;
    sc_d      = sc_q;
    case (state_q)
      RUN: begin
        if (mode_p) begin
          scratch_d = cur_seconds;
          hr_d      = '0;
          mn_d      = '0;
          sc_d      = '0;
          // Out-of-range counts skip conversion and edit from 00:00:00.
          state_d   = (cur_seconds >= 17'd86400) ? SET_H : CONV_H;
        end
      end
      CONV_H: begin
        if (scratch_q >= 17'd3600) begin
          scratch_d = scratch_q - 17'd3600;
          hr_d      = hr_q + 5'd1;
        end else begin
          state_d = CONV_M;
        end
      end
      CONV_M: begin
        if (scratch_q >= 17'd60) begin
          scratch_d = scratch_q - 17'd60;
          mn_d      = mn_q + 6'd1;
        end else begin
          sc_d    = scratch_q[5:0];
          state_d = SET_H;
        end
      end
      SET_H: begin
        if (mode_p) state_d = SET_M;
        else        hr_d = 5'(step_field({1'b0, hr_q}, 6'd23, up_p, down_p));
      end
      SET_M: begin
        if (mode_p) state_d = SET_S;
        else        mn_d = step_field(mn_q, 6'd59, up_p, down_p);
      end
      SET_S: begin
        if (mode_p) state_d = APPLY;
        else        sc_d = step_field(sc_q, 6'd59, up_p, down_p);
      end
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    load_value_d = 17'(hr_q) * 17'd3600 + 17'(mn_q) * 17'd60 + 17'(sc_q);
    blank_d      = '0;
    case (state_q)
      SET_H:   blank_d[5:4] = {2{~onehz}};
      SET_M:   blank_d[3:2] = {2{~onehz}};
      SET_S:   blank_d[1:0] = {2{~onehz}};
      default: blank_d      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_level_q   <= '0;
      db_prev_q    <= '0;
      db_cnt_q     <= '0;
      state_q      <= RUN;
      scratch_q    <= '0;
      hr_q         <= '0;
      mn_q         <= '0;
      sc_q         <= '0;
      load_value_q <= '0;
      blank_q      <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      db_level_q   <= db_level_d;
      db_prev_q    <= db_level_q;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      scratch_q    <= scratch_d;
      hr_q         <= hr_d;
      mn_q         <= mn_d;
      sc_q         <= sc_d;
      load_value_q <= load_value_d;
      blank_q      <= blank_d;
    end
  end

  assign setting    = (state_q != RUN);
  assign load       = (state_q == APPLY);
  assign load_value = load_value_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: load pulses are checked against a queue of
// expected load values pushed when the final mode press is driven.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        onehz = 1'b1;
  logic [16:0] cur_seconds = '0;
  logic        setting, load;
  logic [16:0] load_value;
  logic [7:0]  blank_mask;

  int checks = 0;
  int failures = 0;
  int load_count = 0;
  int lc;
  bit expect_setting_low = 1'b0;
  logic [16:0] exp_q[$];

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .onehz(onehz), .cur_seconds(cur_seconds), .setting(setting), .load(load),
    .load_value(load_value), .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a button combination for 'hold' cycles, release, then let it settle.
  task automatic press(input logic m, input logic u, input logic d, input int hold);
    btn_mode = m; btn_up = u; btn_down = d;
    cycles(hold);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cycles(8);
  endtask

  task automatic enter_set(input logic [16:0] secs);
    cur_seconds = secs;
    press(1'b1, 1'b0, 1'b0, 8);
    cycles(100);
  endtask

  always @(negedge clk) begin
    if (expect_setting_low) begin
      chk("setting_after_load", 32'(setting), 32'd0);
      expect_setting_low = 1'b0;
    end
    if (load === 1'b1) begin
      load_count++;
      if (exp_q.size() == 0) chk("unexpected_load", 32'(load), 32'd0);
      else                   chk("load_value", 32'(load_value), 32'(exp_q.pop_front()));
      expect_setting_low = 1'b1;
    end
  end

  initial begin
    cycles(2);
    chk("rst_setting", 32'(setting), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_load_value", 32'(load_value), 32'd0);
    chk("rst_blank", 32'(blank_mask), 32'd0);
    rst = 1'b1;
    cycles(3);

    // Snapshot 12:34:56 and edit hours
    enter_set(17'd45296);
    chk("snap_setting", 32'(setting), 32'd1);
    chk("snap_value", 32'(load_value), 32'd45296);
    onehz = 1'b0;
    cycles(2);
    chk("blink_h", 32'(blank_mask), 32'h30);
    onehz = 1'b1;
    cycles(2);
    chk("blink_h_off", 32'(blank_mask), 32'h00);
    press(1'b0, 1'b1, 1'b0, 2);
    chk("glitch_ignored", 32'(load_value), 32'd45296);
    press(1'b0, 1'b1, 1'b0, 10);
    chk("hold_one_press", 32'(load_value), 32'd48896);
    press(1'b0, 1'b0, 1'b1, 8);
    chk("down_hour", 32'(load_value), 32'd45296);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    chk("in_set_s", 32'(setting), 32'd1);
    exp_q.push_back(17'd45296);
    lc = load_count;
    press(1'b1, 1'b0, 1'b0, 8);
    chk("load_pulse_1", 32'(load_count), 32'(lc + 1));

    // Up-wrap from 23:59:59
    enter_set(17'd86399);
    chk("snap_max", 32'(load_value), 32'd86399);
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    chk("wrap_up_fields", 32'(load_value), 32'd0);
    exp_q.push_back(17'd0);
    lc = load_count;
    press(1'b1, 1'b0, 1'b0, 8);
    chk("load_pulse_2", 32'(load_count), 32'(lc + 1));

    // Down-wrap from 00:00:00
    enter_set(17'd0);
    chk("snap_zero_setting", 32'(setting), 32'd1);
    press(1'b0, 1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b0, 1'b0, 1'b1, 8);
    exp_q.push_back(17'd86399);
    lc = load_count;
    press(1'b1, 1'b0, 1'b0, 8);
    chk("load_pulse_3", 32'(load_count), 32'(lc + 1));

    // Invalid snapshot, blink in SET_M, mode+up priority, reset mid-edit
    enter_set(17'd90000);
    chk("invalid_setting", 32'(setting), 32'd1);
    chk("invalid_zero", 32'(load_value), 32'd0);
    press(1'b1, 1'b0, 1'b0, 8);
    for (int i = 0; i < 6; i++) begin
      onehz = i[0];
      @(negedge clk);
      chk("blink_m", 32'(blank_mask), onehz ? 32'h00 : 32'h0C);
    end
    onehz = 1'b0;
    press(1'b1, 1'b1, 1'b0, 8);
    chk("mode_up_mn_same", 32'(load_value), 32'd0);
    chk("mode_up_in_set_s", 32'(blank_mask), 32'h03);
    lc = load_count;
    rst = 1'b0;
    #1;
    chk("midreset_setting", 32'(setting), 32'd0);
    chk("midreset_load", 32'(load), 32'd0);
    chk("midreset_blank", 32'(blank_mask), 32'd0);
    cycles(2);
    rst = 1'b1;
    cycles(10);
    chk("after_reset_setting", 32'(setting), 32'd0);
    chk("no_load_after_reset", 32'(load_count), 32'(lc));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("total_loads", 32'(load_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
